// File: rtl/segment_pkg.sv
// ---------------------------------------------------------------------------
// segment_pkg
//   Shared definitions for the segment FSM and its path driver: state
//   encodings, controller state type, and the two pure functions that
//   describe the FSM's transition table and which targets are still
//   reachable from a given state.
// ---------------------------------------------------------------------------
package segment_pkg;

    localparam int STATE_W = 8;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_A = STATE_W'(0);
    localparam state_t ST_B = STATE_W'(1);
    localparam state_t ST_C = STATE_W'(2);
    localparam state_t ST_D = STATE_W'(3);
    localparam state_t ST_E = STATE_W'(4);

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_WALK = 2'd1,
        CTRL_RESP = 2'd2
    } ctrl_e;

    // Transition table of the segment FSM. Any illegal encoding falls back
    // to A so the mirror can never get stuck outside the legal set.
    function automatic state_t seg_next(input state_t state, input logic i);
        state_t nxt;
        case (state)
            ST_A:    nxt = i ? ST_B : ST_A;
            ST_B:    nxt = i ? ST_C : ST_D;
            ST_C:    nxt = ST_B;
            ST_D:    nxt = ST_E;
            ST_E:    nxt = ST_E;
            default: nxt = ST_A;
        endcase
        return nxt;
    endfunction

    // Can target t still be reached from mirror state m? A is only reachable
    // by staying there; D and E are absorbing towards E, so B/C/D are lost
    // once the walk has entered D or E.
    function automatic logic seg_reachable(input state_t m, input state_t t);
        logic ok;
        case (t)
            ST_A:             ok = (m == ST_A);
            ST_B, ST_C, ST_D: ok = !((m == ST_D) || (m == ST_E));
            ST_E:             ok = 1'b1;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/segment_path_driver_mirror.sv
// ---------------------------------------------------------------------------
// segment_path_driver_mirror
//   Cycle-accurate copy of the segment FSM state, advanced with the same
//   i value that is driven into the real FSM. Compares the FSM's o output
//   against the mirror every cycle and keeps a sticky mismatch flag.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   i_drive_i       value driven onto the FSM's i input this cycle
//   o_obs_i         observed FSM output o
//   state_o         mirror state
//   mismatch_o      sticky disagreement flag (registered)
//   mismatch_set_o  disagreement seen this cycle while flag still clear
//   prop_o          mirror state is one of the five legal encodings
// ---------------------------------------------------------------------------
module segment_path_driver_mirror
    import segment_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_drive_i,
    input  logic   o_obs_i,
    output state_t state_o,
    output logic   mismatch_o,
    output logic   mismatch_set_o,
    output logic   prop_o
);

    state_t state_q;
    state_t state_d;
    logic   mismatch_q;
    logic   mismatch_d;
    logic   o_diff;

    always_comb begin
        state_d    = seg_next(state_q, i_drive_i);
        o_diff     = (o_obs_i != (state_q == ST_A));
        mismatch_d = mismatch_q | o_diff;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_A;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign state_o        = state_q;
    assign mismatch_o     = mismatch_q;
    assign mismatch_set_o = o_diff & ~mismatch_q;
    assign prop_o         = (state_q <= ST_E);

endmodule

// File: rtl/segment_path_driver.sv
// ---------------------------------------------------------------------------
// segment_path_driver
//   Stimulus-side driver for the 5-state segment FSM. Accepts a target
//   state request, walks the FSM along the shortest path by driving its
//   i input, and reports completion with a one-cycle done pulse.
// Ports
//   clock, reset_n    clock (rising edge), asynchronous active-low reset
//   req_valid/ready   target request handshake (ready only in IDLE)
//   req_target        requested state, legal 0..4
//   i_drive, drive_en value for FSM input i and its qualifier
//   o_obs             FSM output o, checked against the mirror
//   done_valid/ok/steps  completion pulse, success flag, driven steps
//   mirror_state      current mirror of the FSM state
//   mismatch          sticky o_obs disagreement since reset
//   prop              mirror state is legal
// ---------------------------------------------------------------------------
module segment_path_driver #(
    parameter int STATE_W   = 8,
    parameter int MAX_STEPS = 4,
    parameter int STEP_W    = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [STATE_W-1:0] req_target,
    output logic               i_drive,
    output logic               drive_en,
    input  logic               o_obs,
    output logic               done_valid,
    output logic               done_ok,
    output logic [STEP_W-1:0]  done_steps,
    output logic [STATE_W-1:0] mirror_state,
    output logic               mismatch,
    output logic               prop
);

    import segment_pkg::*;

    ctrl_e              ctrl_q;
    logic [STATE_W-1:0] target_q;
    logic [STEP_W-1:0]  steps_q;
    logic               done_valid_q;
    logic               done_ok_q;
    logic [STEP_W-1:0]  done_steps_q;

    state_t             mirror;
    logic               mismatch_set;
    logic               at_target;
    logic               unreachable;
    logic               step_limit;
    logic               walk_drive;
    logic               path_i;

    // The drive decision is combinational: the mirror and the real FSM both
    // consume i_drive on the same edge that ends the walk cycle.
    // NOTE: every always_comb output gets a value on every path (here by
    // assigning all of them unconditionally) so no latch is inferred.
    always_comb begin
        at_target   = (mirror == target_q);
        unreachable = !seg_reachable(mirror, target_q);
        step_limit  = (steps_q == STEP_W'(MAX_STEPS));
        walk_drive  = (ctrl_q == CTRL_WALK) && !at_target && !unreachable
                      && !step_limit && !mismatch_set;
        // Only A->B and B->C need i=1; every other shortest-path step uses 0.
        path_i      = (mirror == ST_A) || ((mirror == ST_B) && (target_q == ST_C));
    end

    assign drive_en = walk_drive;
    assign i_drive  = walk_drive & path_i;

    segment_path_driver_mirror u_mirror (
        .clk            (clock),
        .rst_n          (reset_n),
        .i_drive_i      (i_drive),
        .o_obs_i        (o_obs),
        .state_o        (mirror),
        .mismatch_o     (mismatch),
        .mismatch_set_o (mismatch_set),
        .prop_o         (prop)
    );

    // Controller with registered done outputs: done_valid_q is set on the
    // transition into RESP, so it is high exactly for the RESP cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q       <= CTRL_IDLE;
            target_q     <= '0;
            steps_q      <= '0;
            done_valid_q <= 1'b0;
            done_ok_q    <= 1'b0;
            done_steps_q <= '0;
        end else begin
            done_valid_q <= 1'b0;
            case (ctrl_q)
                CTRL_IDLE: begin
                    if (req_valid) begin
                        steps_q <= '0;
                        if (req_target > ST_E) begin
                            ctrl_q       <= CTRL_RESP;
                            done_valid_q <= 1'b1;
                            done_ok_q    <= 1'b0;
                            done_steps_q <= '0;
                        end else begin
                            target_q <= req_target;
                            ctrl_q   <= CTRL_WALK;
                        end
                    end
                end
                CTRL_WALK: begin
                    if (at_target) begin
                        ctrl_q       <= CTRL_RESP;
                        done_valid_q <= 1'b1;
                        done_ok_q    <= 1'b1;
                        done_steps_q <= steps_q;
                    end else if (unreachable || step_limit || mismatch_set) begin
                        ctrl_q       <= CTRL_RESP;
                        done_valid_q <= 1'b1;
                        done_ok_q    <= 1'b0;
                        done_steps_q <= steps_q;
                    end else begin
                        steps_q <= steps_q + 1'b1;
                    end
                end
                CTRL_RESP: begin
                    ctrl_q <= CTRL_IDLE;
                end
                default: begin
                    ctrl_q <= CTRL_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = (ctrl_q == CTRL_IDLE);
    assign done_valid   = done_valid_q;
    assign done_ok      = done_ok_q;
    assign done_steps   = done_steps_q;
    assign mirror_state = mirror;

endmodule

// File: tb/tb_segment_path_driver.sv
// ---------------------------------------------------------------------------
// tb_segment_path_driver
//   Directed bench for segment_path_driver. A behavioural segment FSM is
//   driven by the DUT's i_drive and feeds o_obs back (optionally inverted
//   to provoke a mismatch). Expected values are hand-derived per vector.
// ---------------------------------------------------------------------------
module tb_segment_path_driver;

    logic       clock;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_target;
    logic       i_drive;
    logic       drive_en;
    logic       o_obs;
    logic       done_valid;
    logic       done_ok;
    logic [3:0] done_steps;
    logic [7:0] mirror_state;
    logic       mismatch;
    logic       prop;

    logic       obs_inv;
    logic [7:0] fsm_q;
    int         n_checks;
    int         n_errors;

    segment_path_driver #(
        .STATE_W   (8),
        .MAX_STEPS (4),
        .STEP_W    (4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_target   (req_target),
        .i_drive      (i_drive),
        .drive_en     (drive_en),
        .o_obs        (o_obs),
        .done_valid   (done_valid),
        .done_ok      (done_ok),
        .done_steps   (done_steps),
        .mirror_state (mirror_state),
        .mismatch     (mismatch),
        .prop         (prop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the real segment FSM being driven.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q <= 8'd0;
        end else begin
            case (fsm_q)
                8'd0:    fsm_q <= i_drive ? 8'd1 : 8'd0;
                8'd1:    fsm_q <= i_drive ? 8'd2 : 8'd3;
                8'd2:    fsm_q <= 8'd1;
                8'd3:    fsm_q <= 8'd4;
                default: fsm_q <= 8'd4;
            endcase
        end
    end

    assign o_obs = (fsm_q == 8'd0) ^ obs_inv;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Move to the next cycle; returns 2 time units after the rising edge.
    task automatic next_cycle();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_target = 8'd0;
        obs_inv    = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        #1;
    endtask

    // Issue one request in the current cycle (cycle 0) and check every cycle
    // up to and including the done pulse, then the following IDLE cycle.
    task automatic run_req(input string name, input logic [7:0] tgt, input int done_cyc,
                           input logic exp_ok, input logic [3:0] exp_steps,
                           input logic [7:0] i_pat, input logic [7:0] exp_mirror,
                           input int inv_cyc);
        logic exp_en;
        logic exp_i;
        req_valid  = 1'b1;
        req_target = tgt;
        #1;
        check({name, " ready0"}, req_ready, 1'b1);
        for (int c = 0; c <= done_cyc; c++) begin
            if (c > 0) begin
                next_cycle();
                req_valid = 1'b0;
                obs_inv   = (c == inv_cyc);
                #1;
            end
            exp_en = (c >= 1) && (c <= int'(exp_steps));
            exp_i  = exp_en ? i_pat[c-1] : 1'b0;
            check($sformatf("%s en c%0d", name, c), drive_en, exp_en);
            check($sformatf("%s i c%0d", name, c), i_drive, exp_i);
            check($sformatf("%s dv c%0d", name, c), done_valid, c == done_cyc);
        end
        check({name, " ok"}, done_ok, exp_ok);
        check({name, " steps"}, done_steps, exp_steps);
        check({name, " mirror"}, mirror_state, exp_mirror);
        check({name, " ready_resp"}, req_ready, 1'b0);
        next_cycle();
        obs_inv = 1'b0;
        #1;
        check({name, " dv_after"}, done_valid, 1'b0);
        check({name, " ready_after"}, req_ready, 1'b1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_target = 8'd0;
        obs_inv    = 1'b0;

        // Reset values
        do_reset();
        check("rst ready", req_ready, 1'b1);
        check("rst prop", prop, 1'b1);
        check("rst mirror", mirror_state, 8'd0);
        check("rst mismatch", mismatch, 1'b0);
        check("rst done_valid", done_valid, 1'b0);
        check("rst done_ok", done_ok, 1'b0);
        check("rst done_steps", done_steps, 4'd0);
        check("rst drive_en", drive_en, 1'b0);
        check("rst i_drive", i_drive, 1'b0);

        // A -> E: i = 1,0,0; done cycle 5, mirror holds E
        run_req("reqE", 8'd4, 5, 1'b1, 4'd3, 8'b001, 8'd4, -1);
        // From E, B is unreachable
        run_req("reqB_unr", 8'd1, 2, 1'b0, 4'd0, 8'b0, 8'd4, -1);

        // Illegal target 7; a second request during RESP must be ignored
        req_valid  = 1'b1;
        req_target = 8'd7;
        #1;
        check("rej ready0", req_ready, 1'b1);
        check("rej en0", drive_en, 1'b0);
        next_cycle();
        req_target = 8'd0;
        #1;
        check("rej ready_resp", req_ready, 1'b0);
        check("rej dv1", done_valid, 1'b1);
        check("rej ok", done_ok, 1'b0);
        check("rej steps", done_steps, 4'd0);
        check("rej en1", drive_en, 1'b0);
        next_cycle();
        req_valid = 1'b0;
        #1;
        for (int c = 2; c <= 4; c++) begin
            check($sformatf("rej dv c%0d", c), done_valid, 1'b0);
            check($sformatf("rej en c%0d", c), drive_en, 1'b0);
            check($sformatf("rej ready c%0d", c), req_ready, 1'b1);
            next_cycle();
            #1;
        end

        // Boundary: first illegal target
        run_req("rej5", 8'd5, 1, 1'b0, 4'd0, 8'b0, 8'd4, -1);

        // A -> A: no drive, done cycle 2
        do_reset();
        run_req("reqA", 8'd0, 2, 1'b1, 4'd0, 8'b0, 8'd0, -1);
        // A -> C: i = 1,1; arrival momentary, mirror already B at done
        run_req("reqC", 8'd2, 4, 1'b1, 4'd2, 8'b011, 8'd1, -1);
        // Mirror has moved on to D: A is unreachable
        run_req("reqA_unr", 8'd0, 2, 1'b0, 4'd0, 8'b0, 8'd4, -1);

        // Mismatch in IDLE: o_obs forced 0 while mirror = A
        do_reset();
        obs_inv = 1'b1;
        #1;
        check("mm idle before", mismatch, 1'b0);
        next_cycle();
        obs_inv = 1'b0;
        #1;
        check("mm idle set", mismatch, 1'b1);
        next_cycle();
        next_cycle();
        #1;
        check("mm idle sticky", mismatch, 1'b1);

        // Mismatch mid-walk aborts A -> E after one step
        do_reset();
        check("mm walk clear", mismatch, 1'b0);
        run_req("mmE", 8'd4, 3, 1'b0, 4'd1, 8'b001, 8'd3, 2);
        check("mm walk sticky", mismatch, 1'b1);

        // Async reset mid-walk (A -> D)
        do_reset();
        req_valid  = 1'b1;
        req_target = 8'd3;
        next_cycle();
        req_valid = 1'b0;
        #1;
        check("rw en c1", drive_en, 1'b1);
        check("rw i c1", i_drive, 1'b1);
        next_cycle();
        #1;
        check("rw en c2", drive_en, 1'b1);
        check("rw i c2", i_drive, 1'b0);
        check("rw mirror c2", mirror_state, 8'd1);
        reset_n = 1'b0;
        #1;
        check("rw async mirror", mirror_state, 8'd0);
        check("rw async ready", req_ready, 1'b1);
        check("rw async en", drive_en, 1'b0);
        check("rw async i", i_drive, 1'b0);
        check("rw async dv", done_valid, 1'b0);
        check("rw async prop", prop, 1'b1);
        next_cycle();
        reset_n = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rw post dv c%0d", c), done_valid, 1'b0);
            check($sformatf("rw post ready c%0d", c), req_ready, 1'b1);
            check($sformatf("rw post mirror c%0d", c), mirror_state, 8'd0);
            next_cycle();
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
